// File: rtl/linecard_port_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// linecard_port_scheduler : round-robin grant of ingress URAM FIFOs to reader
// Rev 1.0
// ============================================================================
module linecard_port_scheduler #(
   parameter  int NUM_PORTS    = 24,
   parameter  int PTR_BITS     = 13,
   parameter  int MAX_INFLIGHT = 4,
   localparam int PORT_BITS    = $clog2(NUM_PORTS),
   localparam int CNT_BITS     = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS*PTR_BITS-1:0] wr_ptr_committed,
   input  logic [NUM_PORTS*PTR_BITS-1:0] rd_ptr,
   input  logic [NUM_PORTS-1:0]          rd_ptr_reset,
   input  logic [NUM_PORTS-1:0]          port_enable,
   output logic                          grant_valid,
   input  logic                          grant_ready,
   output logic [PORT_BITS-1:0]          grant_port,
   input  logic                          done_valid,
   input  logic [PORT_BITS-1:0]          done_port,
   output logic [NUM_PORTS-1:0]          busy,
   output logic [CNT_BITS-1:0]           inflight,
   output logic                          protocol_error
);

   localparam int                  EXT_PORTS      = 1 << PORT_BITS;
   localparam logic [CNT_BITS-1:0] C_MAX_INFLIGHT = CNT_BITS'(MAX_INFLIGHT);
   localparam logic [PORT_BITS-1:0] C_LAST_PORT   = PORT_BITS'(NUM_PORTS - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   state_t                r_state;
   logic [PORT_BITS-1:0]  r_rr_ptr;

   logic [NUM_PORTS-1:0]  w_nonempty;
   logic [NUM_PORTS-1:0]  w_eligible;
   logic                  w_pick_found;
   logic [PORT_BITS-1:0]  w_pick_port;
   logic [PORT_BITS-1:0]  w_cand;
   logic                  w_accept;
   logic                  w_withdraw;
   logic [EXT_PORTS-1:0]  w_busy_ext;
   logic                  w_done_ok;
   logic                  w_done_err;
   logic [NUM_PORTS-1:0]  w_busy_next;

   // Full-width pointer compare: wrap-around is naturally handled.
   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_nonempty
         assign w_nonempty[gi] =
            (wr_ptr_committed[gi*PTR_BITS +: PTR_BITS] != rd_ptr[gi*PTR_BITS +: PTR_BITS])
            && !rd_ptr_reset[gi];
      end
   endgenerate

   assign w_eligible = w_nonempty & port_enable & ~busy;

   always_comb begin
      w_pick_found = 1'b0;
      w_pick_port  = '0;
      w_cand       = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         w_cand = PORT_BITS'((int'(r_rr_ptr) + k) % NUM_PORTS);
         if (!w_pick_found && w_eligible[w_cand]) begin
            w_pick_found = 1'b1;
            w_pick_port  = w_cand;
         end
      end
   end

   assign w_accept   = (r_state == ST_OFFER) && grant_ready;
   assign w_withdraw = (r_state == ST_OFFER) && !grant_ready &&
                       (rd_ptr_reset[grant_port] || !port_enable[grant_port]);

   // Zero-padded copy so out-of-range done_port values read as not busy.
   assign w_busy_ext = EXT_PORTS'(busy);
   assign w_done_ok  = done_valid && w_busy_ext[done_port];
   assign w_done_err = done_valid && !w_done_ok;

   always_comb begin
      w_busy_next = busy;
      if (w_accept) begin
         w_busy_next[grant_port] = 1'b1;
      end
      if (w_done_ok) begin
         w_busy_next[done_port] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_rr_ptr       <= '0;
         grant_valid    <= 1'b0;
         grant_port     <= '0;
         busy           <= '0;
         inflight       <= '0;
         protocol_error <= 1'b0;
      end else begin
         busy <= w_busy_next;

         if (w_done_err) begin
            protocol_error <= 1'b1;
         end

         if (w_accept && !w_done_ok && (inflight != C_MAX_INFLIGHT)) begin
            inflight <= inflight + 1'b1;
         end else if (!w_accept && w_done_ok && (inflight != '0)) begin
            inflight <= inflight - 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_pick_found && (inflight < C_MAX_INFLIGHT)) begin
                  grant_port  <= w_pick_port;
                  grant_valid <= 1'b1;
                  r_state     <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               // Accept takes priority over a simultaneous withdraw condition.
               if (w_accept) begin
                  grant_valid <= 1'b0;
                  r_rr_ptr    <= (grant_port == C_LAST_PORT) ? '0 : grant_port + 1'b1;
                  r_state     <= ST_IDLE;
               end else if (w_withdraw) begin
                  grant_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               grant_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
